pipe_ctrl: RTL and testbench

- Central pipeline control unit; the producer side of the 6-bit stall vector and the flush signal consumed by every inter-stage register (PC, IF/ID, ID/EX, EX/MEM, MEM/WB).
- Arbitrates per-stage stall requests and MEM-stage exception/ERET events.
- Drives a registered flush pulse and redirect PC.
- Provides a consecutive-stall watchdog flag.

---
 rtl/pipe_ctrl.sv | 116 +++++++++++
 tb/tb_pipe_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall arbitration, exception flush/redirect and stall watchdog.
// Optional statistics counters are enabled with `define PIPE_CTRL_STATS_EN.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR    = 32'hBFC0_0380,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic        exc_valid,
    input  logic        exc_eret,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
`ifdef PIPE_CTRL_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [15:0] flush_count,
`endif
    output logic        stall_timeout
);

    typedef enum logic [0:0] {StRun, StFlush} state_e;

    localparam logic [15:0] WdLimit = 16'(STALL_TIMEOUT - 1);

    state_e      state_q;
    logic [15:0] wd_cnt_q;
    logic        exc_accept;
    logic [5:0]  stall_raw;
    logic        stall_active;

    // An exception is only taken once MEM is no longer waiting on the data bus.
    assign exc_accept = (state_q == StRun) && exc_valid && !stallreq_mem;

    always_comb begin
        stall_raw = 6'b000000;
        if (state_q == StRun) begin
            if (exc_accept || stallreq_mem) begin
                stall_raw = 6'b011111;
            end else if (stallreq_ex) begin
                stall_raw = 6'b001111;
            end else if (stallreq_id) begin
                stall_raw = 6'b000111;
            end else if (stallreq_if) begin
                stall_raw = 6'b000011;
            end
        end
    end

    // Stall must read zero while reset is held, independent of requests.
    assign stall        = rst ? stall_raw : 6'b000000;
    assign stall_active = |stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StRun;
            flush   <= 1'b0;
            new_pc  <= 32'h0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (exc_accept) begin
                        new_pc  <= exc_eret ? cp0_epc : EXC_VECTOR;
                        flush   <= 1'b1;
                        state_q <= StFlush;
                    end
                end
                StFlush: begin
                    flush   <= 1'b0;
                    state_q <= StRun;
                end
                default: begin
                    flush   <= 1'b0;
                    state_q <= StRun;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt_q      <= 16'h0;
            stall_timeout <= 1'b0;
        end else if (stall_active) begin
            if (wd_cnt_q != 16'hFFFF) begin
                wd_cnt_q <= wd_cnt_q + 16'd1;
            end
            if (wd_cnt_q >= WdLimit) begin
                stall_timeout <= 1'b1;
            end
        end else begin
            wd_cnt_q <= 16'h0;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cycles <= 32'h0;
            flush_count  <= 16'h0;
        end else begin
            if (stall_active) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl, watchdog limit shortened to 8 cycles.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        exc_valid = 1'b0;
    logic        exc_eret = 1'b0;
    logic [31:0] cp0_epc = 32'h0;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
`ifdef PIPE_CTRL_STATS_EN
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    pipe_ctrl #(
        .EXC_VECTOR   (32'hBFC0_0380),
        .STALL_TIMEOUT(8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_valid    (exc_valid),
        .exc_eret     (exc_eret),
        .cp0_epc      (cp0_epc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
`ifdef PIPE_CTRL_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .stall_timeout(stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        exc_valid    = 1'b0;
        exc_eret     = 1'b0;
    endtask

    initial begin
        // Reset values, with requests high to show stall is forced low.
        stallreq_mem = 1'b1;
        #12;
        check("rst_stall", {26'b0, stall}, 32'h0);
        check("rst_flush", {31'b0, flush}, 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        check("rst_timeout", {31'b0, stall_timeout}, 32'h0);
        idle();
        rst = 1'b1;
        tick();

        // Priority encoding, combinational within one cycle.
        stallreq_if = 1'b1; stallreq_id = 1'b1; stallreq_ex = 1'b1; #1;
        check("prio_ex", {26'b0, stall}, 32'h0F);
        stallreq_mem = 1'b1; #1;
        check("prio_mem", {26'b0, stall}, 32'h1F);
        stallreq_mem = 1'b0; stallreq_ex = 1'b0; #1;
        check("prio_id", {26'b0, stall}, 32'h07);
        stallreq_id = 1'b0; #1;
        check("prio_if", {26'b0, stall}, 32'h03);
        idle(); #1;
        check("prio_none", {26'b0, stall}, 32'h00);

        // Plain exception.
        tick();
        exc_valid = 1'b1; stallreq_if = 1'b1; #1;
        check("exc_T_stall", {26'b0, stall}, 32'h1F);
        check("exc_T_flush", {31'b0, flush}, 32'h0);
        tick();
        idle(); #1;
        check("exc_T1_flush", {31'b0, flush}, 32'h1);
        check("exc_T1_pc", new_pc, 32'hBFC0_0380);
        check("exc_T1_stall", {26'b0, stall}, 32'h0);
        tick();
        check("exc_T2_flush", {31'b0, flush}, 32'h0);

        // ERET.
        exc_valid = 1'b1; exc_eret = 1'b1; cp0_epc = 32'h8000_1234; #1;
        tick();
        idle(); #1;
        check("eret_flush", {31'b0, flush}, 32'h1);
        check("eret_pc", new_pc, 32'h8000_1234);
        tick();
        check("eret_end", {31'b0, flush}, 32'h0);

        // ERET held off by a MEM stall for 3 cycles.
        exc_valid = 1'b1; exc_eret = 1'b1; stallreq_mem = 1'b1; cp0_epc = 32'h8000_5678; #1;
        check("mwait_stall", {26'b0, stall}, 32'h1F);
        tick();
        check("mwait_flush1", {31'b0, flush}, 32'h0);
        tick();
        check("mwait_flush2", {31'b0, flush}, 32'h0);
        tick();
        check("mwait_flush3", {31'b0, flush}, 32'h0);
        stallreq_mem = 1'b0; #1;
        check("mwait_acc_stall", {26'b0, stall}, 32'h1F);
        tick();
        idle(); #1;
        check("mwait_flush", {31'b0, flush}, 32'h1);
        check("mwait_pc", new_pc, 32'h8000_5678);
        tick();
        check("mwait_end", {31'b0, flush}, 32'h0);

        // Requests ignored during FLUSH, back-to-back acceptance after it.
        exc_valid = 1'b1; #1;
        tick();
        stallreq_ex = 1'b1; #1;
        check("mask_stall", {26'b0, stall}, 32'h0);
        check("mask_flush", {31'b0, flush}, 32'h1);
        tick();
        exc_eret = 1'b1; cp0_epc = 32'h1234_5678; #1;
        check("b2b_stall", {26'b0, stall}, 32'h1F);
        check("b2b_flush0", {31'b0, flush}, 32'h0);
        tick();
        idle(); #1;
        check("b2b_flush", {31'b0, flush}, 32'h1);
        check("b2b_pc", new_pc, 32'h1234_5678);
        tick();
        check("b2b_end", {31'b0, flush}, 32'h0);

        // Watchdog: 7 stalled cycles must not trip it.
        stallreq_id = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        stallreq_id = 1'b0; #1;
        check("wd7_timeout", {31'b0, stall_timeout}, 32'h0);
        tick();
        check("wd7_after", {31'b0, stall_timeout}, 32'h0);

        // 8 stalled cycles trip it on the 8th edge.
        stallreq_id = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        check("wd8_pre", {31'b0, stall_timeout}, 32'h0);
        tick();
        check("wd8_set", {31'b0, stall_timeout}, 32'h1);
        stallreq_id = 1'b0;
        tick();
        check("wd8_sticky", {31'b0, stall_timeout}, 32'h1);
        exc_valid = 1'b1; #1;
        tick();
        idle(); #1;
        check("wd_flush_keep", {31'b0, stall_timeout}, 32'h1);

        // Asynchronous reset in the middle of a FLUSH cycle.
        stallreq_id = 1'b1; rst = 1'b0; #1;
        check("arst_flush", {31'b0, flush}, 32'h0);
        check("arst_pc", new_pc, 32'h0);
        check("arst_timeout", {31'b0, stall_timeout}, 32'h0);
        check("arst_stall", {26'b0, stall}, 32'h0);
        idle();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_flush", {31'b0, flush}, 32'h0);

`ifdef PIPE_CTRL_STATS_EN
        check("stats_rst_cyc", stall_cycles, 32'h0);
        check("stats_rst_fl", {16'b0, flush_count}, 32'h0);
        stallreq_if = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        idle();
        tick();
        for (int i = 0; i < 2; i++) begin
            exc_valid = 1'b1; #1;
            tick();
            idle();
            tick();
            tick();
        end
        check("stats_cycles", stall_cycles, 32'd7);
        check("stats_flushes", {16'b0, flush_count}, 32'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule
